key_ctrl: RTL

KEY_CTRL -- requirements
Module: key_ctrl

---
 rtl/key_ctrl_if.sv | 10 +
 rtl/key_ctrl.sv | 92 +++++++++
 2 files changed

// File: rtl/key_ctrl_if.sv
// Register-bridge port bundle for key_ctrl: word address, write strobe, write and read data.
interface key_ctrl_if;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;

  modport master (output Addr, output WE, output Din, input Dout);
  modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/key_ctrl.sv
// Eight-key debouncer with a bridge register file (STATE/PEND/MASK/CTRL) and a level interrupt.
// Each key is synchronised, debounced by a stability counter, and raises PEND on an accepted edge.
module key_ctrl #(
  parameter int unsigned DB_LIMIT = 500000,
  parameter int unsigned DB_W     = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] key_n,
  key_ctrl_if.slave  bus,
  output logic       IRQ
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_LIMIT - 1);

  logic [7:0]      sync1_q, sync2_q;
  logic [7:0]      ks;
  logic [7:0]      st_q, st_d;
  logic [DB_W-1:0] cnt_q [8];
  logic [DB_W-1:0] cnt_d [8];
  logic [7:0]      pend_q, pend_d;
  logic [7:0]      mask_q, mask_d;
  logic            both_q, both_d;
  logic            ie_q, ie_d;
  logic            irq_q, irq_d;
  logic [7:0]      rise, fall, w1c;
  logic            wr_pend, wr_mask, wr_ctrl;
  logic            unused_din;

  assign ks = ~sync2_q;

  // A bounce back to the accepted level restarts the count from zero.
  for (genvar gi = 0; gi < 8; gi++) begin : g_db
    assign cnt_d[gi] = (ks[gi] == st_q[gi] || cnt_q[gi] == CNT_LAST)
                       ? '0 : cnt_q[gi] + DB_W'(1);
    assign st_d[gi]  = (ks[gi] != st_q[gi] && cnt_q[gi] == CNT_LAST)
                       ? ks[gi] : st_q[gi];
  end

  assign rise    = st_d & ~st_q;
  assign fall    = ~st_d & st_q;
  assign wr_pend = bus.WE && bus.Addr == 2'd1;
  assign wr_mask = bus.WE && bus.Addr == 2'd2;
  assign wr_ctrl = bus.WE && bus.Addr == 2'd3;
  assign w1c     = wr_pend ? bus.Din[7:0] : 8'h00;

  // Set is OR-ed after the clear so a same-edge event survives a W1C.
  assign pend_d = (pend_q & ~w1c) | rise | (both_q ? fall : 8'h00);
  assign mask_d = wr_mask ? bus.Din[7:0] : mask_q;
  assign both_d = wr_ctrl ? bus.Din[1] : both_q;
  assign ie_d   = wr_ctrl ? bus.Din[0] : ie_q;
  assign irq_d  = ie_q & (|(pend_q & mask_q));

  assign unused_din = ^bus.Din[31:8];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 8'hFF;
      sync2_q <= 8'hFF;
      st_q    <= 8'h00;
      pend_q  <= 8'h00;
      mask_q  <= 8'h00;
      both_q  <= 1'b0;
      ie_q    <= 1'b0;
      irq_q   <= 1'b0;
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      st_q    <= st_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      both_q  <= both_d;
      ie_q    <= ie_d;
      irq_q   <= irq_d;
      for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    bus.Dout = 32'h0;
    case (bus.Addr)
      2'd0:    bus.Dout = {24'h0, st_q};
      2'd1:    bus.Dout = {24'h0, pend_q};
      2'd2:    bus.Dout = {24'h0, mask_q};
      default: bus.Dout = {30'h0, both_q, ie_q};
    endcase
  end

  assign IRQ = irq_q;

endmodule
